// File: rtl/score4_link_pkg.sv
// Shared definitions for the board-to-board move link.
// Used by the transmitter (move_link_tx) and the matching receiver.
//   op_t        : 2-bit move opcode carried in every frame
//   tx_state_t  : transmitter bit-sequencing states
//   FRAME_BITS  : start + 2 data + parity + stop
//   build_frame : frame image, LSB is sent first
package score4_link_pkg;

    typedef enum logic [1:0] {
        OP_SYNC  = 2'b00,
        OP_LEFT  = 2'b01,
        OP_RIGHT = 2'b10,
        OP_PUT   = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA0,
        ST_DATA1,
        ST_PARITY,
        ST_STOP,
        ST_GAP
    } tx_state_t;

    localparam int FRAME_BITS = 5;

    // {stop, even parity, op[1], op[0], start}
    function automatic logic [FRAME_BITS-1:0] build_frame(input op_t op);
        return {1'b1, op[1] ^ op[0], op[1], op[0], 1'b0};
    endfunction

endpackage

// File: rtl/move_link_tx_if.sv
// Signal bundle between the local turn/event logic and the move link
// transmitter.
//   turn, left_pulse, right_pulse, put_pulse, sync_req : towards the transmitter
//   tx, busy, drop, overflow, fifo_count               : from the transmitter
// slave  : transmitter side
// master : event source / observer side
interface move_link_tx_if #(
    parameter int FIFO_DEPTH = 4
);
    logic                        turn;
    logic                        left_pulse;
    logic                        right_pulse;
    logic                        put_pulse;
    logic                        sync_req;
    logic                        tx;
    logic                        busy;
    logic                        drop;
    logic                        overflow;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    modport master (
        output turn, left_pulse, right_pulse, put_pulse, sync_req,
        input  tx, busy, drop, overflow, fifo_count
    );

    modport slave (
        input  turn, left_pulse, right_pulse, put_pulse, sync_req,
        output tx, busy, drop, overflow, fifo_count
    );
endinterface

// File: rtl/link_fifo.sv
// Small event FIFO for the move link transmitter.
//   clk, rst   : clock, async active-low reset
//   flush      : empty the FIFO; a simultaneous push lands in entry 0
//   push/data  : write request; ignored when full unless a pop happens too
//   pop/data   : read request; pop_data shows the head combinationally
//   full/empty : occupancy flags
//   count      : occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module link_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign pop_data = mem[rd_ptr];

    // A pop frees the slot in the same cycle, so a full FIFO can still push.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk) begin
        if (flush) begin
            if (push) begin
                mem[0] <= push_data;
            end
        end else if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= push ? PW'(1) : '0;
            cnt    <= push ? CW'(1) : '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/move_link_tx.sv
// Move link transmitter: turns local left/right/put event pulses into
// UART-style frames towards the opponent board.
//   clk, rst : system clock, async active-low reset
//   lnk      : move_link_tx_if.slave
//     turn        in  : local player's turn, gates event acceptance
//     left/right/put_pulse in : one-cycle move events
//     sync_req    in  : flush queue and send a SYNC frame
//     tx          out : serial line, idle high
//     busy        out : frame/gap in progress or events queued
//     drop        out : one-cycle pulse, an offered event was discarded
//     overflow    out : sticky, an event hit a full FIFO
//     fifo_count  out : queued events
//
// state     | meaning
// ----------+---------------------------------------------
// ST_IDLE   | line high, pop next event when queue non-empty
// ST_START  | start bit (0)
// ST_DATA0  | op[0]
// ST_DATA1  | op[1]
// ST_PARITY | op[0]^op[1]
// ST_STOP   | stop bit (1)
// ST_GAP    | one idle bit time before the next frame
module move_link_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic           clk,
    input  logic           rst,
    move_link_tx_if.slave  lnk
);
    import score4_link_pkg::*;

    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t             state, state_next;
    logic [CNT_W-1:0]      bit_cnt, cnt_next;
    logic [FRAME_BITS-1:0] shreg, shreg_next;
    logic                  tx_r, tx_next;

    logic                  turn_q;
    logic                  lock, lock_next;
    logic                  drop_r, drop_next;
    logic                  ovf_r, ovf_set;

    logic                  fifo_flush;
    logic                  fifo_push;
    op_t                   push_op;
    logic                  fifo_pop;
    logic [1:0]            pop_data;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_cnt;

    logic                  any_ev;
    logic                  multi_ev;

    link_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (push_op),
        .pop       (fifo_pop),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

    assign any_ev   = lnk.left_pulse | lnk.right_pulse | lnk.put_pulse;
    assign multi_ev = (lnk.put_pulse & (lnk.left_pulse | lnk.right_pulse))
                    | (lnk.left_pulse & lnk.right_pulse);

    // Event acceptance. sync_req overrides everything; a put that finds the
    // FIFO full still locks so the opponent cannot be sent a later move.
    always_comb begin
        fifo_flush = 1'b0;
        fifo_push  = 1'b0;
        push_op    = OP_SYNC;
        lock_next  = lock;
        drop_next  = 1'b0;
        ovf_set    = 1'b0;

        if (lnk.sync_req) begin
            fifo_flush = 1'b1;
            fifo_push  = 1'b1;
            push_op    = OP_SYNC;
            lock_next  = 1'b0;
            drop_next  = lnk.turn & any_ev;
        end else begin
            if (turn_q & ~lnk.turn) begin
                lock_next = 1'b0;
            end
            if (lnk.turn & any_ev) begin
                if (lock) begin
                    drop_next = 1'b1;
                end else begin
                    if (lnk.put_pulse) begin
                        push_op   = OP_PUT;
                        lock_next = 1'b1;
                    end else if (lnk.left_pulse) begin
                        push_op = OP_LEFT;
                    end else begin
                        push_op = OP_RIGHT;
                    end
                    fifo_push = 1'b1;
                    if (multi_ev) begin
                        drop_next = 1'b1;
                    end
                    if (fifo_full & ~fifo_pop) begin
                        drop_next = 1'b1;
                        ovf_set   = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            turn_q <= 1'b0;
            lock   <= 1'b0;
            drop_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            turn_q <= lnk.turn;
            lock   <= lock_next;
            drop_r <= drop_next;
            ovf_r  <= ovf_r | ovf_set;
        end
    end

    // Bit sequencer. The shift register moves one bit per state advance,
    // so shreg[0] is always the bit being sent from START through STOP.
    always_comb begin
        state_next = state;
        cnt_next   = bit_cnt;
        shreg_next = shreg;
        fifo_pop   = 1'b0;
        tx_next    = 1'b1;

        if (state == ST_IDLE) begin
            if (!fifo_empty) begin
                fifo_pop   = 1'b1;
                shreg_next = build_frame(op_t'(pop_data));
                state_next = ST_START;
                cnt_next   = RELOAD;
            end
        end else if (bit_cnt != '0) begin
            cnt_next = bit_cnt - CNT_W'(1);
        end else begin
            cnt_next   = RELOAD;
            shreg_next = {1'b1, shreg[FRAME_BITS-1:1]};
            case (state)
                ST_START:  state_next = ST_DATA0;
                ST_DATA0:  state_next = ST_DATA1;
                ST_DATA1:  state_next = ST_PARITY;
                ST_PARITY: state_next = ST_STOP;
                ST_STOP:   state_next = ST_GAP;
                default:   state_next = ST_IDLE;
            endcase
        end

        case (state_next)
            ST_START, ST_DATA0, ST_DATA1, ST_PARITY, ST_STOP:
                tx_next = shreg_next[0];
            default:
                tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shreg   <= '1;
            tx_r    <= 1'b1;
        end else begin
            state   <= state_next;
            bit_cnt <= cnt_next;
            shreg   <= shreg_next;
            tx_r    <= tx_next;
        end
    end

    assign lnk.tx         = tx_r;
    assign lnk.busy       = (state != ST_IDLE) | (fifo_cnt != '0);
    assign lnk.drop       = drop_r;
    assign lnk.overflow   = ovf_r;
    assign lnk.fifo_count = fifo_cnt;

endmodule

// File: tb/tb_move_link_tx.sv
// Bench for move_link_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_move_link_tx;

    localparam int C = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    move_link_tx_if #(.FIFO_DEPTH(4)) lnk ();

    move_link_tx #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .lnk (lnk.slave)
    );

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // Independent line receiver: samples each bit in its middle.
    typedef struct packed {
        logic [1:0] op;
        logic       ok;
    } frm_t;
    frm_t frames[$];

    initial begin
        int         t;
        logic [5:0] b;
        bit         act;
        act = 0; t = 0; b = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                act = 0;
            end else if (!act) begin
                if (lnk.tx === 1'b0) begin
                    act = 1; t = 0;
                end
            end else begin
                t++;
            end
            if (act) begin
                if (t % C == C / 2) b[t / C] = lnk.tx;
                if (t == 6 * C - 1) begin
                    frames.push_back('{op: {b[2], b[1]},
                                       ok: (b[0] == 1'b0) && (b[3] == (b[1] ^ b[2]))
                                           && (b[4] == 1'b1) && (b[5] == 1'b1)});
                    act = 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset(input logic t);
        rst = 1'b0;
        lnk.turn = t;
        lnk.left_pulse = 0; lnk.right_pulse = 0; lnk.put_pulse = 0; lnk.sync_req = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        frames.delete();
    endtask

    task automatic sync_edge();
        @(posedge clk); #1;
    endtask

    task automatic apply(input logic l, input logic r, input logic p, input logic s);
        lnk.left_pulse = l; lnk.right_pulse = r; lnk.put_pulse = p; lnk.sync_req = s;
        @(posedge clk); #1;
        lnk.left_pulse = 0; lnk.right_pulse = 0; lnk.put_pulse = 0; lnk.sync_req = 0;
    endtask

    task automatic wait_frame(input string name, input logic [1:0] op);
        int n;
        frm_t f;
        n = 0;
        while (frames.size() == 0 && n < 200) begin
            @(negedge clk); n++;
        end
        if (frames.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL %s: no frame within 200 cycles, expected op %0b", name, op);
        end else begin
            f = frames.pop_front();
            check({name, "_op"}, f.op, op);
            check({name, "_fmt"}, f.ok, 1'b1);
        end
    endtask

    task automatic expect_idle(input string name);
        repeat (40) @(negedge clk);
        check({name, "_nframes"}, frames.size(), 0);
        check({name, "_busy"}, lnk.busy, 1'b0);
    endtask

    typedef struct {
        logic       turn, l, r, p, s;
        logic       exp_drop;
        logic [2:0] exp_cnt;
        logic       exp_frame;
        logic [1:0] exp_op;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          turn l  r  p  s   drop cnt frame op
        vecs[0]  = '{1, 0, 0, 1, 0,  0, 1, 1, 2'b11};
        vecs[1]  = '{1, 1, 1, 0, 0,  1, 1, 1, 2'b01};
        vecs[2]  = '{1, 1, 0, 1, 0,  1, 1, 1, 2'b11};
        vecs[3]  = '{0, 0, 0, 1, 0,  0, 0, 0, 2'b00};
        vecs[4]  = '{1, 0, 1, 0, 0,  0, 1, 1, 2'b10};
        vecs[5]  = '{1, 0, 0, 0, 0,  0, 0, 0, 2'b00};
        vecs[6]  = '{1, 0, 0, 0, 1,  0, 1, 1, 2'b00};
        vecs[7]  = '{1, 1, 0, 0, 1,  1, 1, 1, 2'b00};
        vecs[8]  = '{0, 0, 0, 1, 1,  0, 1, 1, 2'b00};
        vecs[9]  = '{1, 1, 1, 1, 0,  1, 1, 1, 2'b11};
        vecs[10] = '{0, 1, 1, 0, 0,  0, 0, 0, 2'b00};

        // Reset values.
        do_reset(1'b0);
        @(negedge clk);
        check("rst_tx", lnk.tx, 1'b1);
        check("rst_busy", lnk.busy, 1'b0);
        check("rst_drop", lnk.drop, 1'b0);
        check("rst_ovf", lnk.overflow, 1'b0);
        check("rst_cnt", lnk.fifo_count, 0);

        // Single-cycle acceptance vectors, each from a fresh reset.
        for (int i = 0; i < 11; i++) begin
            do_reset(vecs[i].turn);
            sync_edge();
            apply(vecs[i].l, vecs[i].r, vecs[i].p, vecs[i].s);
            @(negedge clk);
            check($sformatf("vec%0d_drop", i), lnk.drop, vecs[i].exp_drop);
            check($sformatf("vec%0d_cnt", i), lnk.fifo_count, vecs[i].exp_cnt);
            check($sformatf("vec%0d_ovf", i), lnk.overflow, 1'b0);
            @(negedge clk);
            check($sformatf("vec%0d_drop_end", i), lnk.drop, 1'b0);
            if (vecs[i].exp_frame) wait_frame($sformatf("vec%0d", i), vecs[i].exp_op);
            else                   expect_idle($sformatf("vec%0d", i));
        end

        // Exact PUT frame timing: pulse in cycle 10, start bit from cycle 12.
        do_reset(1'b1);
        do begin @(posedge clk); #1; end while (cyc != 10);
        lnk.put_pulse = 1'b1;
        @(posedge clk); #1 lnk.put_pulse = 1'b0;
        for (int c = 11; c <= 37; c++) begin
            logic etx, ebusy;
            @(negedge clk);
            etx   = !((c >= 12 && c <= 15) || (c >= 24 && c <= 27));
            ebusy = (c >= 11 && c <= 35);
            check($sformatf("put_tx_c%0d", c), lnk.tx, etx);
            check($sformatf("put_busy_c%0d", c), lnk.busy, ebusy);
        end
        wait_frame("put_timing", 2'b11);

        // Lock after PUT: moves dropped until turn falls.
        sync_edge();
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("lock_drop", lnk.drop, 1'b1);
        check("lock_cnt", lnk.fifo_count, 0);
        expect_idle("lock");
        sync_edge();
        lnk.turn = 1'b0;
        repeat (2) @(posedge clk);
        #1 lnk.turn = 1'b1;
        repeat (2) @(posedge clk);
        #1 apply(1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("unlock_drop", lnk.drop, 1'b0);
        check("unlock_cnt", lnk.fifo_count, 1);
        wait_frame("unlock", 2'b10);

        // Burst of 6 lefts: 5 accepted, 6th hits a full FIFO.
        do_reset(1'b1);
        sync_edge();
        begin
            int   bcnt[6];
            logic bdrp[6];
            bcnt = '{1, 1, 2, 3, 4, 4};
            bdrp = '{0, 0, 0, 0, 0, 1};
            lnk.left_pulse = 1'b1;
            for (int i = 0; i < 6; i++) begin
                @(posedge clk); #1;
                if (i == 5) lnk.left_pulse = 1'b0;
                @(negedge clk);
                check($sformatf("burst_cnt%0d", i), lnk.fifo_count, bcnt[i]);
                check($sformatf("burst_drop%0d", i), lnk.drop, bdrp[i]);
            end
        end
        check("burst_ovf", lnk.overflow, 1'b1);
        for (int i = 0; i < 5; i++) wait_frame($sformatf("burst_f%0d", i), 2'b01);
        expect_idle("burst");
        check("burst_cnt_end", lnk.fifo_count, 0);
        check("burst_ovf_sticky", lnk.overflow, 1'b1);

        // Async reset in the middle of DATA0 of a RIGHT frame.
        do_reset(1'b1);
        sync_edge();
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #2;
        check("mid_pre_tx", lnk.tx, 1'b0);
        rst = 1'b0;
        #1;
        check("mid_rst_tx", lnk.tx, 1'b1);
        check("mid_rst_busy", lnk.busy, 1'b0);
        check("mid_rst_cnt", lnk.fifo_count, 0);
        @(posedge clk); #1 rst = 1'b1;
        frames.delete();
        @(negedge clk);
        check("mid_post_busy", lnk.busy, 1'b0);
        sync_edge();
        apply(1'b0, 1'b0, 1'b1, 1'b0);
        wait_frame("mid_put", 2'b11);
        expect_idle("mid_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/move_link_tx.md
Name: move_link_tx

Overview:
Serial transmitter for the board-to-board move link. It converts local left/right/put event pulses, accepted only during the local turn, into framed UART-style symbols on a single wire to the opponent board. A small FIFO absorbs bursts. A sync request emits a resynchronisation frame on restart. It sits between the local input edge-detect stage and the inter-board connector, alongside the communication/turn logic.

Parameters:
CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); must be >= 2
FIFO_DEPTH, 4, event FIFO entries; power of two, >= 2

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
turn  input  1  1 = local player's turn; gates event acceptance
left_pulse  input  1  one-cycle local cursor-left event
right_pulse  input  1  one-cycle local cursor-right event
put_pulse  input  1  one-cycle local token-drop event
sync_req  input  1  one-cycle request to send a resync frame (game restart)
tx  output  1  serial line; idle high
busy  output  1  1 while a frame or inter-frame gap is in progress, or FIFO non-empty
drop  output  1  one-cycle pulse: an offered event was discarded
overflow  output  1  sticky: an event was discarded because the FIFO was full
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: tx=1, busy=0, drop=0, overflow=0, fifo_count=0, FSM=IDLE, lock=0. Asynchronous: tx returns high immediately, even mid-frame.
- Opcodes (2 bits): 00 SYNC, 01 LEFT, 10 RIGHT, 11 PUT.
- Frame, each bit held exactly CLKS_PER_BIT cycles: start(0), op[0], op[1], parity = op[0]^op[1] (even parity), stop(1). An inter-frame gap of one bit time at tx=1 follows. Total is 6 bit times per frame.
- Acceptance, evaluated each cycle:
  - An event is accepted only if turn=1 and lock=0.
  - Simultaneous pulses: priority PUT > LEFT > RIGHT. Only the winner is enqueued. drop pulses if any loser existed.
  - An accepted PUT sets lock=1. While lock=1, all left/right/put pulses are dropped (drop=1).
  - A falling edge of turn (registered previous value 1, now 0) clears lock.
  - Pulses arriving while turn=0 are silently ignored; they do not assert drop.
- FIFO full:
  - An accepted event is discarded, drop=1, overflow=1 (sticky until reset).
  - An accepted PUT discarded this way still sets lock.
- sync_req:
  - Flushes the FIFO, clears lock, then writes SYNC to entry 0 in the same cycle, so fifo_count=1 next cycle.
  - It wins over any simultaneous event pulse, which is dropped with drop=1.
  - A frame already in flight completes unaltered.
- FSM states: IDLE, START, DATA0, DATA1, PARITY, STOP, GAP.
  - IDLE: if FIFO non-empty, pop into the shift register and go to START.
  - Each subsequent state lasts CLKS_PER_BIT cycles, counted by a bit counter. The counter reloads on every state change.
  - GAP then returns to IDLE.
- Latency: with the FSM IDLE and the FIFO empty, an event pulse in cycle N is written into the FIFO at edge N+1. The FSM pops at edge N+2, so tx falls at edge N+2. Back-to-back frames: the next start bit begins the cycle after GAP ends plus one IDLE cycle.
- Simultaneous FIFO write and pop: fifo_count is unchanged, and pop and push are both permitted even when the FIFO is full.
- Pointers wrap modulo FIFO_DEPTH. fifo_count never exceeds FIFO_DEPTH.
- busy = (FSM != IDLE) | (fifo_count != 0), registered/derived combinationally from registered state only.

Decomposition:
- Shared package score4_link_pkg holds:
  - the op_t enum (OP_SYNC=2'b00, OP_LEFT=2'b01, OP_RIGHT=2'b10, OP_PUT=2'b11)
  - the tx_state_t enum
  - FRAME_BITS=5
  The matching receiver imports the same package.
- One sub-module: link_fifo (parameterised depth, width 2, push/pop/full/empty/count).

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset, turn=1, put_pulse at cycle 10 -> tx low from cycle 12 for 4 cycles, then 1,1,0,1 each for 4 cycles, then 4 gap cycles high. busy deasserts at cycle 36. lock=1 afterwards.
- turn=1, left_pulse and right_pulse in the same cycle -> one LEFT frame (data 1,0, parity 1) is sent; drop=1 for one cycle; no RIGHT frame.
- turn=1, 6 left_pulses on consecutive cycles -> 5 accepted (one popped immediately, 4 queued), 6th dropped. overflow=1, fifo_count peaks at 4. Exactly 5 LEFT frames follow.
- After a PUT, further left_pulse -> drop=1, no frame. Then turn 1->0->1 and right_pulse -> RIGHT frame sent.
- turn=0, put_pulse -> no frame, drop=0, fifo_count stays 0.
- Mid-data-bit rst low -> tx=1 immediately. After rst high, busy=0, fifo_count=0, and the next put_pulse produces a clean frame.
